modexp_ctrl: RTL and testbench

MODEXP_CTRL -- requirements
Module: modexp_ctrl

---
 rtl/modexp_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_modexp_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/modexp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : modexp_ctrl
// Brief    : Modular exponentiation sequencer driving an external Montgomery
//            multiplier (square-and-multiply, single multiply, Montgomery ladder).
// Revision : 1.0 - initial release
// ============================================================================
module modexp_ctrl #(
    parameter int WIDTH     = 512,
    parameter int EXP_WIDTH = 512,
    localparam int CNT_W    = $clog2(EXP_WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [1:0]           mode,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     rmodm,
    input  logic [WIDTH-1:0]     r2modm,
    input  logic [EXP_WIDTH-1:0] exponent,
    input  logic [CNT_W-1:0]     exp_len,
    output logic                 mul_start,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [WIDTH-1:0]     mul_result,
    input  logic                 mul_done,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [WIDTH-1:0]     result
);

    localparam logic [WIDTH-1:0]     c_one     = WIDTH'(1);
    localparam logic [EXP_WIDTH-1:0] c_exp_one = EXP_WIDTH'(1);
    localparam logic [CNT_W-1:0]     c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0]     c_exp_max = CNT_W'(EXP_WIDTH);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        TOMONT   = 3'd1,
        LOOP     = 3'd2,
        FROMMONT = 3'd3,
        DRAIN    = 3'd4,
        FIN      = 3'd5
    } state_t;

    state_t                 r_state, w_next_state;
    logic [1:0]             r_mode;
    logic [WIDTH-1:0]       r_x, r_r2modm, r_xt, r_a, r_r1, r_result;
    logic [WIDTH-1:0]       r_mul_a, r_mul_b, w_op_a, w_op_b;
    logic [EXP_WIDTH-1:0]   r_exp;
    logic [CNT_W-1:0]       r_len, r_idx;
    logic                   r_phase, r_inflight, r_mul_start, r_err;
    logic                   w_issue, w_complete, w_illegal, w_bit, w_bit_end, w_last;

    assign w_illegal = (mode == 2'b11) || (exp_len > c_exp_max);
    // r_idx counts remaining exponent bits; the current bit is exponent[r_idx-1]
    assign w_bit     = |(r_exp & (c_exp_one << (r_idx - c_cnt_one)));
    assign w_last    = (r_idx == c_cnt_one);
    assign w_bit_end = r_mode[1] ? r_phase : (r_phase || !w_bit);

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_complete   = 1'b0;
        w_op_a       = r_mul_a;
        w_op_b       = r_mul_b;
        case (r_state)
            IDLE: begin
                if (start) w_next_state = w_illegal ? FIN : TOMONT;
            end
            TOMONT, LOOP, FROMMONT: begin
                if (abort) begin
                    w_next_state = (r_inflight && !mul_done) ? DRAIN : IDLE;
                end else if (r_inflight) begin
                    if (mul_done) begin
                        w_complete = 1'b1;
                        case (r_state)
                            TOMONT: begin
                                if (r_mode == 2'b01)           w_next_state = FIN;
                                else if (r_len == '0)          w_next_state = FROMMONT;
                                else                           w_next_state = LOOP;
                            end
                            LOOP:    if (w_bit_end && w_last)  w_next_state = FROMMONT;
                            default:                           w_next_state = FIN;
                        endcase
                    end
                end else begin
                    w_issue = 1'b1;
                    case (r_state)
                        TOMONT: begin
                            w_op_a = r_x;
                            w_op_b = r_r2modm;
                        end
                        LOOP: begin
                            if (!r_mode[1]) begin
                                w_op_a = r_a;
                                w_op_b = r_phase ? r_xt : r_a;
                            end else if (!r_phase) begin
                                w_op_a = r_a;
                                w_op_b = r_r1;
                            end else if (w_bit) begin
                                w_op_a = r_r1;
                                w_op_b = r_r1;
                            end else begin
                                w_op_a = r_a;
                                w_op_b = r_a;
                            end
                        end
                        default: begin
                            w_op_a = r_a;
                            w_op_b = c_one;
                        end
                    endcase
                end
            end
            DRAIN: begin
                if (!r_inflight || mul_done) w_next_state = IDLE;
            end
            FIN:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode      <= '0;
            r_x         <= '0;
            r_r2modm    <= '0;
            r_xt        <= '0;
            r_a         <= '0;
            r_r1        <= '0;
            r_result    <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_exp       <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_phase     <= 1'b0;
            r_inflight  <= 1'b0;
            r_mul_start <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_mul_start <= w_issue;
            if (w_issue) begin
                r_mul_a    <= w_op_a;
                r_mul_b    <= w_op_b;
                r_inflight <= 1'b1;
            end else if (mul_done) begin
                r_inflight <= 1'b0;
            end

            if (r_state == IDLE && start) begin
                r_mode   <= mode;
                r_x      <= x;
                r_a      <= rmodm;
                r_r2modm <= r2modm;
                r_exp    <= exponent;
                r_len    <= exp_len;
                r_err    <= w_illegal;
                if (w_illegal) r_result <= '0;
            end

            if (w_complete) begin
                case (r_state)
                    TOMONT: begin
                        r_xt    <= mul_result;
                        r_r1    <= mul_result;
                        r_idx   <= r_len;
                        r_phase <= 1'b0;
                        if (r_mode == 2'b01) r_result <= mul_result;
                    end
                    LOOP: begin
                        // Ladder writes R1 when phase matches the bit, else R0
                        if (r_mode[1] && (r_phase == w_bit)) r_r1 <= mul_result;
                        else                                 r_a  <= mul_result;
                        if (w_bit_end) begin
                            r_phase <= 1'b0;
                            r_idx   <= r_idx - c_cnt_one;
                        end else begin
                            r_phase <= 1'b1;
                        end
                    end
                    default: r_result <= mul_result;
                endcase
            end
        end
    end

    assign mul_start = r_mul_start;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == FIN);
    assign error     = (r_state == FIN) && r_err;
    assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_modexp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_modexp_ctrl
// Brief    : Scoreboard bench for modexp_ctrl with a behavioural Montgomery
//            multiplier (m=13, R=256) of random latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_modexp_ctrl;

    localparam int WIDTH = 8;
    localparam int EXP_WIDTH = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] x = 8'd0;
    logic [7:0] rmodm = 8'd9;
    logic [7:0] r2modm = 8'd3;
    logic [7:0] exponent = 8'd0;
    logic [3:0] exp_len = 4'd0;
    logic       mul_start;
    logic [7:0] mul_a, mul_b;
    logic [7:0] mul_result = 8'd0;
    logic       mul_done = 1'b0;
    logic       busy, done, error;
    logic [7:0] result;

    modexp_ctrl #(.WIDTH(WIDTH), .EXP_WIDTH(EXP_WIDTH)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
        .x(x), .rmodm(rmodm), .r2modm(r2modm), .exponent(exponent), .exp_len(exp_len),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_result(mul_result), .mul_done(mul_done),
        .busy(busy), .done(done), .error(error), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        int res;
        int err;
        int nmul;
        int base;
        int stamp;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_starts = 0;
    logic prev_md = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, expv);
        end
    endtask

    // Reference arithmetic: Mont(a,b) = a*b*R^-1 mod 13, with R^-1 = 3
    function automatic int mont(input int a, input int b);
        return (a * b * 3) % 13;
    endfunction

    function automatic int pow_mod(input int b, input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = (r * (b % 13)) % 13;
        return r;
    endfunction

    function automatic int popc(input int v);
        int c = 0;
        for (int i = 0; i < 32; i++) c += (v >> i) & 1;
        return c;
    endfunction

    // Behavioural multiplier
    bit   m_pend = 0;
    bit   m_unst = 0;
    int   m_cnt = 0;
    int   force_lat = 0;
    logic [7:0] m_pa, m_pb;

    always @(posedge clk) begin
        mul_done <= 1'b0;
        if (m_pend) begin
            if (busy && (mul_a !== m_pa || mul_b !== m_pb)) m_unst = 1;
            if (m_cnt <= 1) begin
                mul_done   <= 1'b1;
                mul_result <= 8'(mont(int'(m_pa), int'(m_pb)));
                m_pend = 0;
                chk("operand_stable", 32'(m_unst), 32'd0);
            end else begin
                m_cnt--;
            end
        end
        if (mul_start) begin
            if (m_pend) chk("overlap", 32'd1, 32'd0);
            m_pend = 1;
            m_unst = 0;
            m_cnt  = (force_lat != 0) ? force_lat : int'($urandom_range(1, 20));
            m_pa   = mul_a;
            m_pb   = mul_b;
        end
    end

    // Monitor: pops an expectation on every done pulse
    always @(negedge clk) begin
        exp_t e;
        if (mul_start) n_starts++;
        if (error && !done) chk("error_without_done", 32'd1, 32'd0);
        if (done) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("result", 32'(result), 32'(e.res));
                chk("error", 32'(error), 32'(e.err));
                chk("mul_count", 32'(n_starts - e.base), 32'(e.nmul));
                if (e.err != 0) chk("err_latency", 32'(cyc - e.stamp), 32'd1);
                else            chk("done_after_mul_done", 32'(prev_md), 32'd1);
            end
        end
        prev_md = mul_done;
    end

    task automatic issue(input int md, input int xv, input int ev, input int lv, input bit push);
        exp_t t;
        int   ee;
        if (push) begin
            t.base  = n_starts;
            t.stamp = cyc;
            if (md == 3 || lv > EXP_WIDTH) begin
                t.res = 0; t.err = 1; t.nmul = 0;
            end else if (md == 1) begin
                t.res = (xv * 256) % 13; t.err = 0; t.nmul = 1;
            end else begin
                ee    = ev & ((1 << lv) - 1);
                t.res = pow_mod(xv, ee);
                t.err = 0;
                t.nmul = (md == 0) ? 2 + lv + popc(ee) : 2 + 2 * lv;
            end
            sbq.push_back(t);
        end
        start    = 1'b1;
        mode     = 2'(md);
        x        = 8'(xv);
        exponent = 8'(ev);
        exp_len  = 4'(lv);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || m_pend) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 3000) chk("idle_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_starts(input int target);
        int n = 0;
        while (n_starts < target && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) chk("start_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int base;
        int md, lv;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_mul_start", 32'(mul_start), 32'd0);
        chk("rst_result", 32'(result), 32'd0);

        issue(0, 2, 5, 3, 1); wait_idle();
        issue(2, 2, 5, 3, 1); wait_idle();
        issue(2, 2, 2, 3, 1); wait_idle();
        issue(1, 2, 0, 0, 1); wait_idle();
        issue(0, 2, 5, 0, 1); wait_idle();
        issue(2, 7, 0, 0, 1); wait_idle();
        issue(3, 2, 5, 3, 1); wait_idle();
        issue(0, 2, 5, EXP_WIDTH + 1, 1); wait_idle();
        issue(2, 3, 8'hFF, 8, 1); wait_idle();

        // Abort with a multiply pending, start ignored while draining
        force_lat = 20;
        base = n_starts;
        issue(0, 2, 5, 3, 0);
        wait_starts(base + 1);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        chk("drain_busy", 32'(busy), 32'd1);
        issue(0, 2, 5, 3, 0);
        wait_idle();
        chk("drain_busy_after", 32'(busy), 32'd0);
        chk("drain_no_new_mul", 32'(n_starts - base), 32'd1);

        // Abort before any multiply is issued
        base = n_starts;
        issue(0, 2, 5, 3, 0);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        chk("abort_idle_busy", 32'(busy), 32'd0);
        wait_idle();
        chk("abort_idle_no_mul", 32'(n_starts - base), 32'd0);
        force_lat = 0;

        issue(0, 2, 5, 3, 1); wait_idle();
        chk("result_hold", 32'(result), 32'd6);

        // Reset mid-loop followed by a late mul_done
        force_lat = 10;
        base = n_starts;
        issue(2, 3, 8'hA5, 8, 0);
        wait_starts(base + 3);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_result", 32'(result), 32'd0);
        chk("midrst_mul_start", 32'(mul_start), 32'd0);
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("late_done_busy", 32'(busy), 32'd0);
        chk("late_done_result", 32'(result), 32'd0);
        chk("late_done_no_mul", 32'(n_starts - base), 32'd3);
        force_lat = 0;

        for (int i = 0; i < 40; i++) begin
            md = int'($urandom_range(0, 2));
            lv = int'($urandom_range(0, 8));
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0) md = 3;
                else lv = int'($urandom_range(9, 15));
            end
            issue(md, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), lv, 1);
            wait_idle();
        end

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
